tinyalu_core: RTL and testbench

- Synthesizable TinyALU responder: the DUT side of the `start`/`done` command protocol driven by the TinyALU BFM.
- Accepts two unsigned 8-bit operands and a 3-bit opcode, computes add/and/xor in one cycle or multiply through a short pipeline, and returns a 16-bit result with a one-cycle `done` pulse.
- Sits directly under the UVM environment's interface as the design under test.

---
 rtl/tinyalu_pkg.sv | 41 ++++
 rtl/tinyalu_mul_pipe.sv | 39 +++
 rtl/tinyalu_core.sv | 127 ++++++++++++
 tb/tb_tinyalu_core.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// TinyALU shared types: opcodes, FSM states and the single-cycle result function.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op   = 3'b000,
        add_op  = 3'b001,
        and_op  = 3'b010,
        xor_op  = 3'b011,
        mul_op  = 3'b100,
        rsv5_op = 3'b101,
        rsv6_op = 3'b110,
        rst_op  = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_1,
        BUSY_M,
        DONE_WAIT
    } tinyalu_state_t;

    localparam logic [15:0] ILLEGAL_RESULT = 16'hDEAD;
    localparam int MCNT_W = 2;

    // Reserved opcodes fall through to the marker value.
    function automatic logic [15:0] alu_single(
        input operation_t  o,
        input logic [7:0]  a,
        input logic [7:0]  b
    );
        logic [15:0] r;
        case (o)
            add_op:  r = {7'b0, {1'b0, a} + {1'b0, b}};
            and_op:  r = {8'b0, a & b};
            xor_op:  r = {8'b0, a ^ b};
            default: r = ILLEGAL_RESULT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// Registered 8x8 unsigned multiplier, STAGES deep, with valid tracking and flush.
module tinyalu_mul_pipe
    import tinyalu_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        flush,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        valid_out,
    output logic [15:0] prod
);

    logic [15:0]       p_q [STAGES];
    logic [STAGES-1:0] v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                p_q[i] <= '0;
            end
        end else begin
            v_q[0] <= valid_in & ~flush;
            p_q[0] <= {8'b0, a} * {8'b0, b};
            for (int i = 1; i < STAGES; i++) begin
                v_q[i] <= v_q[i-1] & ~flush;
                p_q[i] <= p_q[i-1];
            end
        end
    end

    assign valid_out = v_q[STAGES-1];
    assign prod      = p_q[STAGES-1];

endmodule

// File: rtl/tinyalu_core.sv
// TinyALU start/done responder: FSM, operand capture and single-cycle ops.
// Define TINYALU_ILLEGAL_DONE_EN to answer reserved opcodes with 16'hDEAD.
module tinyalu_core
    import tinyalu_pkg::*;
#(
    parameter int MUL_STAGES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  operation_t  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result
);

    logic [1:0]        rst_sync;
    logic              rst_n;
    tinyalu_state_t    state, state_d;
    logic [MCNT_W-1:0] mcnt, mcnt_d;
    logic [7:0]        a_q, b_q;
    operation_t        op_q;
    logic              done_d;
    logic [15:0]       result_d;
    logic              single, capture, mul_start, flush;
    logic              mul_valid;
    logic [15:0]       mul_prod;

    // Assert immediately, release two edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

`ifdef TINYALU_ILLEGAL_DONE_EN
    assign single = op inside {add_op, and_op, xor_op, rsv5_op, rsv6_op, rst_op};
`else
    assign single = op inside {add_op, and_op, xor_op};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcnt   <= '0;
            done   <= 1'b0;
            result <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= no_op;
        end else begin
            state  <= state_d;
            mcnt   <= mcnt_d;
            done   <= done_d;
            result <= result_d;
            if (capture) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op;
            end
        end
    end

    always_comb begin
        state_d   = state;
        mcnt_d    = mcnt;
        done_d    = 1'b0;
        result_d  = result;
        capture   = 1'b0;
        mul_start = 1'b0;
        flush     = 1'b0;
        case (state)
            IDLE: begin
                if (start && op == mul_op) begin
                    capture   = 1'b1;
                    mul_start = 1'b1;
                    mcnt_d    = MCNT_W'(MUL_STAGES - 1);
                    state_d   = BUSY_M;
                end else if (start && single) begin
                    capture = 1'b1;
                    state_d = BUSY_1;
                end
            end
            BUSY_1: begin
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    result_d = alu_single(op_q, a_q, b_q);
                    done_d   = 1'b1;
                    state_d  = DONE_WAIT;
                end
            end
            BUSY_M: begin
                if (!start) begin
                    flush   = 1'b1;
                    mcnt_d  = '0;
                    state_d = IDLE;
                end else if (mcnt == '0 && mul_valid) begin
                    result_d = mul_prod;
                    done_d   = 1'b1;
                    state_d  = DONE_WAIT;
                end else if (mcnt != '0) begin
                    mcnt_d = mcnt - MCNT_W'(1);
                end
            end
            DONE_WAIT: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    tinyalu_mul_pipe #(
        .STAGES (MUL_STAGES)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (mul_start),
        .flush     (flush),
        .a         (A),
        .b         (B),
        .valid_out (mul_valid),
        .prod      (mul_prod)
    );

endmodule

// File: tb/tb_tinyalu_core.sv
// Directed vector bench for tinyalu_core: table of commands plus hand sequences
// for hold-after-done, reset mid-multiply and abort.
module tb_tinyalu_core;
    import tinyalu_pkg::*;

    localparam int MS = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  A, B;
    operation_t  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    int n_vec  = 0;
    int n_miss = 0;
    logic [15:0] model = 16'h0000;

    tinyalu_core #(.MUL_STAGES(MS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  o;
        bit          exp_done;
        logic [15:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] o, input bit exp_done,
                          input logic [15:0] exp_res, input int exp_lat,
                          input string nm);
        int seen;
        seen  = -1;
        A     = a;
        B     = b;
        op    = operation_t'(o);
        start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) begin
                seen = c;
                break;
            end
            if (!exp_done && c == 2) break;
        end
        if (exp_done) begin
            chk({nm, "_latency"}, seen, exp_lat);
            chk({nm, "_result"}, int'(result), int'(exp_res));
            model = exp_res;
            start = 1'b0;
            @(negedge clk);
            chk({nm, "_done_pulse"}, int'(done), 0);
        end else begin
            chk({nm, "_no_done"}, seen, -1);
            start = 1'b0;
            @(negedge clk);
            chk({nm, "_result_held"}, int'(result), int'(model));
        end
    endtask

    initial begin
        int seen;
        tbl.push_back('{8'hFF, 8'h01, 3'b001, 1'b1, 16'h0100, 1});
        tbl.push_back('{8'hFF, 8'hFF, 3'b100, 1'b1, 16'hFE01, MS});
        tbl.push_back('{8'hF0, 8'h3C, 3'b010, 1'b1, 16'h0030, 1});
        tbl.push_back('{8'hF0, 8'h3C, 3'b011, 1'b1, 16'h00CC, 1});
        tbl.push_back('{8'h7F, 8'h01, 3'b001, 1'b1, 16'h0080, 1});
        tbl.push_back('{8'h12, 8'h34, 3'b100, 1'b1, 16'h03A8, MS});
        tbl.push_back('{8'h55, 8'hAA, 3'b000, 1'b0, 16'h0000, 0});
        tbl.push_back('{8'h00, 8'h00, 3'b001, 1'b1, 16'h0000, 1});
        tbl.push_back('{8'h10, 8'h10, 3'b100, 1'b1, 16'h0100, MS});
        tbl.push_back('{8'hFF, 8'h00, 3'b011, 1'b1, 16'h00FF, 1});
`ifdef TINYALU_ILLEGAL_DONE_EN
        tbl.push_back('{8'h11, 8'h22, 3'b101, 1'b1, 16'hDEAD, 1});
        tbl.push_back('{8'h05, 8'h06, 3'b001, 1'b1, 16'h000B, 1});
        tbl.push_back('{8'h11, 8'h22, 3'b111, 1'b1, 16'hDEAD, 1});
`else
        tbl.push_back('{8'h11, 8'h22, 3'b101, 1'b0, 16'h0000, 0});
        tbl.push_back('{8'h05, 8'h06, 3'b001, 1'b1, 16'h000B, 1});
        tbl.push_back('{8'h11, 8'h22, 3'b111, 1'b0, 16'h0000, 0});
`endif

        reset_n = 1'b0;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        op      = no_op;
        @(negedge clk);
        @(negedge clk);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        foreach (tbl[i]) begin
            do_cmd(tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].exp_done,
                   tbl[i].res, tbl[i].lat, $sformatf("v%0d", i));
        end

        // start held 5 cycles beyond done
        A     = 8'h03;
        B     = 8'h04;
        op    = add_op;
        start = 1'b1;
        seen  = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) begin
                seen = c;
                break;
            end
        end
        chk("hold_latency", seen, 1);
        chk("hold_result", int'(result), 16'h0007);
        model = 16'h0007;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold_no_retrigger%0d", c),
                int'({done, result}), int'({1'b0, model}));
        end
        start = 1'b0;
        @(negedge clk);

        // reset during cycle 2 of a multiply
        A     = 8'hFF;
        B     = 8'hFF;
        op    = mul_op;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_result", int'(result), 0);
        model = 16'h0000;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen    = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("rst_no_late_done", seen, 0);
        do_cmd(8'h01, 8'h02, 3'b001, 1'b1, 16'h0003, 1, "post_rst_add");

        // abort a multiply, then a single-cycle op
        A     = 8'h02;
        B     = 8'h03;
        op    = mul_op;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("abort_mul_no_done", seen, 0);
        chk("abort_mul_result", int'(result), int'(model));
        do_cmd(8'h0F, 8'h11, 3'b100, 1'b1, 16'h00FF, MS, "post_abort_mul");

        A     = 8'h09;
        B     = 8'h09;
        op    = add_op;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("abort_add_no_done", seen, 0);
        chk("abort_add_result", int'(result), int'(model));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
